// File: rtl/crc32_pkg.sv
// Shared constants, FSM state encoding and the byte-wide CRC-32 update
// (IEEE 802.3, reflected, LSB-first) used by the self-test block.
package crc32_pkg;

   localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_FEED1  = 3'd2,
      ST_FIN1   = 3'd3,
      ST_FEED2  = 3'd4,
      ST_CHECK2 = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // One byte through the reflected CRC-32 register, data bit 0 first.
   function automatic logic [31:0] crc8_step(input logic [31:0] crc_in, input logic [7:0] data);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c[0] = c[0] ^ data[i];
         if (c[0]) begin
            c = {1'b0, c[31:1]} ^ CRC_POLY_R;
         end else begin
            c = {1'b0, c[31:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_selftest_d8.sv
// Registered byte-wide CRC-32 engine: restart on init, absorb din when en.
module crc32_d8
   import crc32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] crc_reg
);

   logic [31:0] crc_d;
   logic [31:0] crc_q;

   // Next CRC: restart takes priority over absorbing a byte, otherwise hold.
   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc8_step(crc_q, din);
      end else begin
         crc_d = crc_q;
      end
   end

   // CRC register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_reg = crc_q;

endmodule

// File: rtl/crc32_selftest.sv
// Self-checking CRC-32 block: feeds the stimulus ROM through the byte engine,
// reports the CRC, then re-feeds message+CRC and checks the residue.
// Outputs are registered from look-ahead on the next state so that each flag
// is visible during the state it belongs to.
module crc32_selftest
   import crc32_pkg::*;
#(
   parameter int   MSG_LEN      = 9,
   parameter int   GAP          = 0,
   parameter logic INJECT_FAULT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        busy,
   output logic        crc_valid,
   output logic [31:0] crc_value,
   output logic        done,
   output logic        pass
);

   localparam logic [31:0] EXP_CRC = 32'hCBF43926;
   localparam logic [8:0]  LAST1   = 9'(MSG_LEN - 1);
   localparam logic [8:0]  LAST2   = 9'(MSG_LEN + 3);
   localparam logic [8:0]  MSG_END = 9'(MSG_LEN);
   localparam logic [3:0]  GAP_V   = 4'(GAP);

   state_t      state_q, state_d;
   logic [8:0]  byte_idx_q, byte_idx_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        ok1_q, ok1_d;
   logic        busy_q, busy_d;
   logic        crc_valid_q, crc_valid_d;
   logic [31:0] crc_value_q, crc_value_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic        feeding_s, feed_en_s, slot_end_s, last_s, eng_init_s;
   logic [1:0]  crc_sel_s;
   logic [7:0]  din_s;
   logic [31:0] crc_reg_s, crc_next_s;

   // Stimulus ROM: ASCII "123456789", zero beyond.
   function automatic logic [7:0] rom_byte(input logic [8:0] idx);
      logic [7:0] b;
      case (idx)
         9'd0:    b = 8'h31;
         9'd1:    b = 8'h32;
         9'd2:    b = 8'h33;
         9'd3:    b = 8'h34;
         9'd4:    b = 8'h35;
         9'd5:    b = 8'h36;
         9'd6:    b = 8'h37;
         9'd7:    b = 8'h38;
         9'd8:    b = 8'h39;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   crc32_d8 u_eng (
      .clk     (clk),
      .rst     (rst),
      .init    (eng_init_s),
      .en      (feed_en_s),
      .din     (din_s),
      .crc_reg (crc_reg_s)
   );

   // Slot timing: a byte is fed when the gap counter is idle; the slot ends after its gap.
   always_comb begin
      feeding_s  = (state_q == ST_FEED1) || (state_q == ST_FEED2);
      feed_en_s  = feeding_s && (gap_cnt_q == 4'd0);
      slot_end_s = feeding_s && (((gap_cnt_q == 4'd0) && (GAP_V == 4'd0)) || (gap_cnt_q == 4'd1));
      eng_init_s = (state_q == ST_INIT) || (state_q == ST_FIN1);
      if (state_q == ST_FEED2) begin
         last_s = (byte_idx_q == LAST2);
      end else begin
         last_s = (byte_idx_q == LAST1);
      end
   end

   // Byte source (ROM, or the reported CRC LSB first in pass 2) and look-ahead CRC.
   always_comb begin
      din_s      = 8'h00;
      crc_next_s = crc_reg_s;
      crc_sel_s  = byte_idx_q[1:0] - MSG_END[1:0];
      if ((state_q == ST_FEED2) && (byte_idx_q >= MSG_END)) begin
         case (crc_sel_s)
            2'd0:    din_s = crc_value_q[7:0];
            2'd1:    din_s = crc_value_q[15:8];
            2'd2:    din_s = crc_value_q[23:16];
            2'd3:    din_s = crc_value_q[31:24];
            default: din_s = 8'h00;
         endcase
      end else if (byte_idx_q == 9'd0) begin
         din_s = rom_byte(byte_idx_q) ^ {7'd0, INJECT_FAULT};
      end else begin
         din_s = rom_byte(byte_idx_q);
      end
      if (feed_en_s) begin
         crc_next_s = crc8_step(crc_reg_s, din_s);
      end else begin
         crc_next_s = crc_reg_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = ST_INIT;
         ST_INIT:   state_d = ST_FEED1;
         ST_FEED1: begin
            if (slot_end_s && last_s) state_d = ST_FIN1;
            else                      state_d = ST_FEED1;
         end
         ST_FIN1:   state_d = ST_FEED2;
         ST_FEED2: begin
            if (slot_end_s && last_s) state_d = ST_CHECK2;
            else                      state_d = ST_FEED2;
         end
         ST_CHECK2: state_d = ST_DONE;
         ST_DONE:   state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Byte index and gap counter.
   always_comb begin
      byte_idx_d = byte_idx_q;
      gap_cnt_d  = gap_cnt_q;
      if (eng_init_s) begin
         byte_idx_d = 9'd0;
         gap_cnt_d  = 4'd0;
      end else if (feeding_s) begin
         if (gap_cnt_q == 4'd0) gap_cnt_d = GAP_V;
         else                   gap_cnt_d = gap_cnt_q - 4'd1;
         if (slot_end_s && !last_s) byte_idx_d = byte_idx_q + 9'd1;
         else                       byte_idx_d = byte_idx_q;
      end else begin
         byte_idx_d = byte_idx_q;
         gap_cnt_d  = gap_cnt_q;
      end
   end

   // Output look-ahead and compare results.
   always_comb begin
      case (state_d)
         ST_INIT, ST_FEED1, ST_FIN1, ST_FEED2, ST_CHECK2: busy_d = 1'b1;
         default:                                         busy_d = 1'b0;
      endcase
      crc_valid_d = (state_d == ST_FIN1);
      done_d      = (state_d == ST_DONE);
      if (state_d == ST_FIN1) crc_value_d = ~crc_next_s;
      else                    crc_value_d = crc_value_q;
      if (state_q == ST_FIN1) ok1_d = (crc_value_q == EXP_CRC);
      else                    ok1_d = ok1_q;
      if (state_q == ST_CHECK2) pass_d = ok1_q && (crc_reg_s == CRC_RESIDUE);
      else                      pass_d = pass_q;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Datapath and output registers; reset aborts any run in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_idx_q  <= 9'd0;
         gap_cnt_q   <= 4'd0;
         ok1_q       <= 1'b0;
         busy_q      <= 1'b0;
         crc_valid_q <= 1'b0;
         crc_value_q <= 32'd0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         byte_idx_q  <= byte_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         ok1_q       <= ok1_d;
         busy_q      <= busy_d;
         crc_valid_q <= crc_valid_d;
         crc_value_q <= crc_value_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign busy      = busy_q;
   assign crc_valid = crc_valid_q;
   assign crc_value = crc_value_q;
   assign done      = done_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_crc32_selftest.sv
// Scoreboard bench: three self-test instances (default, GAP=3, faulted ROM
// byte 0) plus a stand-alone byte engine, checked against a byte-level
// CRC-32 reference model.
`timescale 1ns/1ps
module tb_crc32_selftest;

   localparam int NDUT = 3;

   typedef byte unsigned bq_t[$];
   typedef struct {
      bit          is_done;
      int          cyc;
      logic [31:0] val;
      bit          pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy [NDUT];
   logic        crc_valid [NDUT];
   logic        done [NDUT];
   logic        pass [NDUT];
   logic [31:0] crc_value [NDUT];

   logic        e_rst, e_init, e_en, e_chk;
   logic [7:0]  e_din;
   logic [31:0] e_crc;

   exp_t        exp_q [NDUT][$];
   logic [31:0] eng_q [$];
   int          done_cyc [NDUT];
   logic [31:0] exp_val [NDUT];
   bit          exp_pass [NDUT];
   bit          done_seen [NDUT];
   bit          armed [NDUT];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rst_smp;

   always #10 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      crc32_selftest #(
         .MSG_LEN      (9),
         .GAP          ((g == 1) ? 3 : 0),
         .INJECT_FAULT ((g == 2) ? 1'b1 : 1'b0)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .busy      (busy[g]),
         .crc_valid (crc_valid[g]),
         .crc_value (crc_value[g]),
         .done      (done[g]),
         .pass      (pass[g])
      );
   end

   crc32_d8 u_eng (
      .clk     (clk),
      .rst     (e_rst),
      .init    (e_init),
      .en      (e_en),
      .din     (e_din),
      .crc_reg (e_crc)
   );

   task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got 0x%08h expected 0x%08h (cyc %0d)", name, g, got, exp, cyc);
      end
   endtask

   // Reference: standard reflected CRC-32 register after a byte string (no final XOR).
   function automatic logic [31:0] ref_raw(input bq_t m);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (m[i]) begin
         c = c ^ {24'd0, m[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic bq_t msg_of(input int g);
      bq_t m;
      for (int i = 0; i < 9; i++) m.push_back(8'(8'h31 + i));
      if (g == 2) m[0] = 8'h30;
      return m;
   endfunction

   task automatic push_run();
      bq_t m, m2;
      logic [31:0] crc;
      bit ok1, ok2;
      int slot;
      exp_t e;
      for (int g = 0; g < NDUT; g++) begin
         m   = msg_of(g);
         crc = ~ref_raw(m);
         m2  = m;
         for (int b = 0; b < 4; b++) m2.push_back(8'(crc >> (8 * b)));
         ok1  = (crc == 32'hCBF43926);
         ok2  = (ref_raw(m2) == 32'hDEBB20E3);
         slot = (g == 1) ? 4 : 1;
         e.is_done = 1'b0; e.cyc = 2 + 9 * slot; e.val = crc; e.pass = 1'b0;
         exp_q[g].push_back(e);
         e.is_done = 1'b1; e.cyc = 4 + (2 * 9 + 4) * slot; e.val = crc; e.pass = ok1 && ok2;
         exp_q[g].push_back(e);
         done_cyc[g]  = e.cyc;
         exp_val[g]   = crc;
         exp_pass[g]  = ok1 && ok2;
         done_seen[g] = 1'b0;
         armed[g]     = 1'b1;
      end
   endtask

   task automatic eng_run(input bq_t m, input logic [31:0] expv);
      @(posedge clk); #1;
      e_init = 1'b1; e_en = 1'b0;
      @(posedge clk); #1;
      e_init = 1'b0;
      foreach (m[i]) begin
         e_en = 1'b1; e_din = m[i];
         @(posedge clk); #1;
      end
      e_en = 1'b0;
      eng_q.push_back(expv);
      e_chk = 1'b1;
      @(posedge clk); #1;
      e_chk = 1'b0;
   endtask

   // Cycle count since reset release: 0 = IDLE cycle.
   always @(posedge clk) begin
      rst_smp <= rst;
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < NDUT; g++) begin
         if (rst_smp !== 1'b1) begin
            chk("rst_busy", g, 32'(busy[g]), 32'd0);
            chk("rst_valid", g, 32'(crc_valid[g]), 32'd0);
            chk("rst_value", g, crc_value[g], 32'd0);
            chk("rst_done", g, 32'(done[g]), 32'd0);
            chk("rst_pass", g, 32'(pass[g]), 32'd0);
         end else if (armed[g]) begin
            chk("busy", g, 32'(busy[g]), 32'((cyc >= 1) && (cyc < done_cyc[g])));
            if (crc_valid[g] === 1'b1) begin
               if (exp_q[g].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_valid dut%0d got strobe expected none (cyc %0d)", g, cyc);
               end else begin
                  e = exp_q[g].pop_front();
                  chk("valid_order", g, 32'(e.is_done), 32'd0);
                  chk("valid_cycle", g, 32'(cyc), 32'(e.cyc));
                  chk("crc_value", g, crc_value[g], e.val);
                  if (g != 2) chk("crc_known", g, crc_value[g], 32'hCBF43926);
               end
            end
            if ((done[g] === 1'b1) && !done_seen[g]) begin
               done_seen[g] = 1'b1;
               if (exp_q[g].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done dut%0d got done expected none (cyc %0d)", g, cyc);
               end else begin
                  e = exp_q[g].pop_front();
                  chk("done_order", g, 32'(e.is_done), 32'd1);
                  chk("done_cycle", g, 32'(cyc), 32'(e.cyc));
                  chk("pass", g, 32'(pass[g]), 32'(e.pass));
               end
            end
            if (done_seen[g]) begin
               chk("hold_done", g, 32'(done[g]), 32'd1);
               chk("hold_pass", g, 32'(pass[g]), 32'(exp_pass[g]));
               chk("hold_value", g, crc_value[g], exp_val[g]);
               chk("hold_valid", g, 32'(crc_valid[g]), 32'd0);
            end
         end
      end
      if (e_chk === 1'b1) begin
         if (eng_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL eng_unexpected got check strobe expected none");
         end else begin
            chk("eng_crc", 0, ~e_crc, eng_q.pop_front());
         end
      end
   end

   initial begin
      bq_t m;
      int  tgt;
      rst = 1'b0; e_rst = 1'b0; e_init = 1'b0; e_en = 1'b0; e_din = 8'h00; e_chk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      e_rst = 1'b1;

      // Byte engine: known vectors, then random strings against the model.
      m = {}; m.push_back(8'h00);
      eng_run(m, 32'hD202EF8D);
      m = {}; m.push_back(8'h61);
      eng_run(m, 32'hE8B7BE43);
      for (int t = 0; t < 6; t++) begin
         m = {};
         for (int i = 0; i < $urandom_range(20, 1); i++) m.push_back(8'($urandom_range(255, 0)));
         eng_run(m, ~ref_raw(m));
      end

      // Run 1: aborted by reset while the default instance is in its second pass.
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      rst = 1'b1;
      push_run();
      tgt = $urandom_range(24, 12);
      repeat (tgt) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         armed[g] = 1'b0;
         exp_q[g].delete();
      end
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;

      // Run 2: complete run, then hold in DONE for well over 100 cycles.
      rst = 1'b1;
      push_run();
      repeat (92 + 110) @(posedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) begin
         if (exp_q[g].size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_event dut%0d got %0d pending expected 0", g, exp_q[g].size());
         end
      end
      if (eng_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL eng_missing got %0d pending expected 0", eng_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
